// File: rtl/io_port_bank.sv
// Memory-mapped bank of NCH general-purpose I/O channels: OUT/IN/EDGE/IEN registers per channel,
// pin synchronizers with rising-edge capture, and a level interrupt.
module io_port_bank #(
    parameter int          NCH   = 4,
    parameter int          WIDTH = 8,
    parameter logic [31:0] BASE  = 32'h800
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          adr,
    input  logic [31:0]          wd,
    input  logic                 we,
    input  logic                 re,
    output logic [31:0]          rd,
    output logic                 sel,
    input  logic [NCH*WIDTH-1:0] in_pins,
    output logic [NCH*WIDTH-1:0] out_pins,
    output logic                 irq
);
    localparam int          NB     = NCH * WIDTH;
    localparam logic [32:0] WIN_LO = {1'b0, BASE};
    localparam logic [32:0] WIN_HI = WIN_LO + 33'(16 * NCH);

    logic             in_win;
    logic             wr_en;
    logic [2:0]       chan;
    logic [1:0]       regi;
    logic [NB-1:0]    out_reg, edge_reg, ien_reg;
    logic [NB-1:0]    out_next, edge_next, ien_next;
    logic [NB-1:0]    s1_reg, s2_reg, s3_reg;
    logic [NB-1:0]    rise;
    logic [1:0]       warm_reg;
    logic             capture_en;
    logic [WIDTH-1:0] rd_word;
    logic             unused_wd;

    // BASE is 128-byte aligned, so adr[6:4] is already the channel index inside the window.
    assign in_win     = ({1'b0, adr} >= WIN_LO) && ({1'b0, adr} < WIN_HI);
    assign chan       = adr[6:4];
    assign regi       = adr[3:2];
    assign sel        = (we | re) & in_win;
    assign wr_en      = we & in_win;
    assign rise       = s2_reg & ~s3_reg;
    assign capture_en = (warm_reg == 2'd3);
    assign unused_wd  = ^wd;

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            logic             hit;
            logic [WIDTH-1:0] clr_mask;

            assign hit      = wr_en && (chan == 3'(gi));
            assign clr_mask = (hit && regi == 2'd2) ? wd[WIDTH-1:0] : '0;

            assign out_next[gi*WIDTH +: WIDTH] =
                (hit && regi == 2'd0) ? wd[WIDTH-1:0] : out_reg[gi*WIDTH +: WIDTH];
            assign ien_next[gi*WIDTH +: WIDTH] =
                (hit && regi == 2'd3) ? wd[WIDTH-1:0] : ien_reg[gi*WIDTH +: WIDTH];
            // Clear first, then OR in new edges so a coincident edge survives the W1C.
            assign edge_next[gi*WIDTH +: WIDTH] =
                (edge_reg[gi*WIDTH +: WIDTH] & ~clr_mask) |
                (rise[gi*WIDTH +: WIDTH] & {WIDTH{capture_en}});
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_reg  <= '0;
            edge_reg <= '0;
            ien_reg  <= '0;
            s1_reg   <= '0;
            s2_reg   <= '0;
            s3_reg   <= '0;
            warm_reg <= 2'd0;
        end else begin
            out_reg  <= out_next;
            edge_reg <= edge_next;
            ien_reg  <= ien_next;
            s1_reg   <= in_pins;
            s2_reg   <= s1_reg;
            s3_reg   <= s2_reg;
            warm_reg <= (warm_reg == 2'd3) ? 2'd3 : warm_reg + 2'd1;
        end
    end

    always_comb begin
        rd_word = '0;
        for (int c = 0; c < NCH; c++) begin
            if (chan == 3'(c)) begin
                case (regi)
                    2'd0:    rd_word = out_reg[c*WIDTH +: WIDTH];
                    2'd1:    rd_word = s2_reg[c*WIDTH +: WIDTH];
                    2'd2:    rd_word = edge_reg[c*WIDTH +: WIDTH];
                    default: rd_word = ien_reg[c*WIDTH +: WIDTH];
                endcase
            end
        end
    end

    assign rd       = sel ? 32'(rd_word) : 32'h0;
    assign out_pins = out_reg;
    assign irq      = |(edge_reg & ien_reg);
endmodule

// File: doc/io_port_bank.md
IO_PORT_BANK -- requirements
Module: io_port_bank

Parameters
REQ-001 NCH, default 4: number of I/O channels, legal range 1..8.
REQ-002 WIDTH, default 8: pin width per channel, legal range 1..32.
REQ-003 BASE, default 32'h800: byte address of channel 0; must be 128-byte aligned.

Interface
REQ-004 clk  in  1  clock; reset is asynchronous and active-high.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 adr  in  32  byte address from the core data bus.
REQ-007 wd  in  32  write data.
REQ-008 we  in  1  write strobe (MemWrite).
REQ-009 re  in  1  read strobe (MemtoReg); used only to qualify sel.
REQ-010 rd  out  32  combinational read data.
REQ-011 sel  out  1  high when adr is inside the bank window; steers the core read mux.
REQ-012 in_pins  in  NCH*WIDTH  asynchronous external inputs; channel c occupies bits [c*WIDTH +: WIDTH].
REQ-013 out_pins  out  NCH*WIDTH  registered outputs, using the same channel packing as in_pins.
REQ-014 irq  out  1  level interrupt request.

Function
REQ-015 Window: BASE <= adr < BASE+16*NCH.
- channel = adr[6:4]-relative index (adr-BASE)>>4.
- register = adr[3:2]; adr[1:0] ignored.
REQ-016 Per-channel register map:
- 0 OUT: read/write; drives out_pins.
- 1 IN: read-only; synchronized pins.
- 2 EDGE: sticky rising-edge flags; write-1-to-clear.
- 3 IEN: read/write interrupt enables.
REQ-017 A write takes effect on the clk edge where we=1 and adr is in the window.
- Only wd[WIDTH-1:0] is used.
- Writes to IN are ignored.
REQ-018 rd returns the addressed register zero-extended to 32 bits when sel=1, else 32'h0; rd shall have no read side effects.
REQ-019 sel = (we|re) & in-window; sel is combinational.
REQ-020 Each in_pins bit passes through a 2-flop synchronizer (s1, s2) plus a history flop s3.
- IN = s2.
- Rising edge = s2 & ~s3.
REQ-021 Latency:
- A pin change before clk edge n is visible in IN after edge n+1.
- The EDGE bit sets on edge n+2.
REQ-022 When a W1C write and a new edge hit the same EDGE bit in the same cycle, set wins; EDGE bits not written with 1 are unaffected.
REQ-023 Warm-up counter (2-bit):
- Counts 0..3 after reset deasserts, then holds at 3.
- Edge capture is suppressed while count < 3, so pins high at reset do not produce spurious EDGE bits.
REQ-024 irq = OR over all channels and bits of (EDGE & IEN); irq is combinational from registers with no extra delay.
REQ-025 out_pins changes only on a clk edge following a qualifying OUT write, with no glitching between writes.
REQ-026 Addresses at or above BASE+16*NCH, or below BASE: sel=0, no register changes, rd=0.

Reset
REQ-027 On reset assertion, independent of clk, the following clear to 0:
- OUT, EDGE, IEN;
- s1, s2, s3;
- warm-up counter.
Consequently out_pins=0 and irq=0.
REQ-028 Reset mid-write: the write is discarded and registers stay 0 until the first clk edge after deassertion.
REQ-029 All outputs shall be known (not X) while reset=1.

Verification
REQ-030 Write then read back: NCH=4, WIDTH=8. Write 0xA5 to 0x810 (ch1 OUT) -> out_pins[15:8]=0xA5 after that edge; read 0x810 -> rd=0x000000A5, sel=1.
REQ-031 Synchronizer and edge capture: drive in_pins[16] 0->1 before edge n -> read 0x824 shows 0x01 after edge n+1; EDGE at 0x828 shows 0x01 after edge n+2; irq stays 0 until IEN[0] is set at 0x82C, then irq=1 in that same cycle.
REQ-032 W1C and set-wins: EDGE ch0=0x03; write 0x01 to 0x808 in the cycle a new bit0 edge arrives -> EDGE=0x03; next write 0x03 with no edge -> EDGE=0x00 and irq=0.
REQ-033 Warm-up suppression: in_pins all 1 during reset; release reset -> EDGE remains 0 for all channels, IN=0xFF after 2 edges.
REQ-034 Out-of-window and read-only writes: write 0xFF to 0x840 (NCH=4) -> sel=0, rd=0, no state change; write to 0x804 -> IN unchanged.
REQ-035 Mid-operation reset: assert reset asynchronously mid-cycle with OUT=0x5A, IEN=0xFF -> out_pins=0 and irq=0 immediately, before the next clk edge.
